// File: rtl/apb_gpio_pwm_blinker_if.sv
// APB slave bus bundle for the GPIO pattern generator (zero wait state).
interface apb_gpio_pwm_blinker_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_gpio_pwm_blinker.sv
// Multi-channel APB-programmable GPIO pattern generator (off / on / blink / pwm).
// Channels share one prescaler; period/duty are double-buffered per channel so
// reprogramming a running channel only takes effect at its next period wrap.
module apb_gpio_pwm_blinker #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 24,
  parameter int unsigned PRE_W  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  apb_gpio_pwm_blinker_if.slave apb,
  output logic [NUM_CH-1:0]     gpio_out,
  output logic [NUM_CH-1:0]     gpio_oe,
  output logic [NUM_CH-1:0]     irq
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic wr_en, rd_en, word_ok, glb_hit;
  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign rd_en   = apb.psel & ~apb.pwrite;
  assign word_ok = (apb.paddr[1:0] == 2'b00);
  assign glb_hit = (apb.paddr == 8'h00);

  logic             en;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  mode_e             mode [NUM_CH];
  logic [NUM_CH-1:0] inv, ie, blink;
  logic [CNT_W-1:0]  period_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_sh    [NUM_CH];
  logic [CNT_W-1:0]  period_act [NUM_CH];
  logic [CNT_W-1:0]  duty_act   [NUM_CH];
  logic [CNT_W-1:0]  cnt        [NUM_CH];

  logic [NUM_CH-1:0] mode_wr, period_wr, duty_wr, running, wrap, raw, oe_d;
  logic [31:0]       rdata;
  logic [23:0]       cnt24;

  logic unused_pwdata;
  assign unused_pwdata = ^apb.pwdata;

  assign tick = en && (pre_cnt == prescale);

  // Per-channel write decode, wrap detection and raw pattern level
  always_comb begin
    mode_wr   = '0;
    period_wr = '0;
    duty_wr   = '0;
    running   = '0;
    wrap      = '0;
    raw       = '0;
    oe_d      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_en && word_ok && (apb.paddr[7:4] == 4'(c + 1))) begin
        mode_wr[c]   = (apb.paddr[3:2] == 2'd0);
        period_wr[c] = (apb.paddr[3:2] == 2'd1);
        duty_wr[c]   = (apb.paddr[3:2] == 2'd2);
      end
      running[c] = en && ((mode[c] == MODE_BLINK) || (mode[c] == MODE_PWM));
      // a MODE write in the same cycle swallows the tick for that channel
      wrap[c]    = running[c] && tick && !mode_wr[c] && (cnt[c] == period_act[c]);
      oe_d[c]    = (mode[c] != MODE_OFF);
      case (mode[c])
        MODE_OFF:   raw[c] = 1'b0;
        MODE_ON:    raw[c] = 1'b1;
        MODE_BLINK: raw[c] = blink[c];
        MODE_PWM:   raw[c] = (cnt[c] < duty_act[c]);
        default:    raw[c] = 1'b0;
      endcase
    end
  end

  // GLOBAL register: enable and shared prescale value
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      en       <= 1'b0;
      prescale <= '0;
    end else if (wr_en && glb_hit) begin
      en       <= apb.pwdata[0];
      prescale <= apb.pwdata[16 +: PRE_W];
    end
  end

  // Shared prescaler: counts 0..prescale, held at 0 while disabled
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)
      pre_cnt <= '0;
    else if (!en || tick)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  // Per-channel configuration and period/duty shadow registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      inv <= '0;
      ie  <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        mode[c]      <= MODE_OFF;
        period_sh[c] <= '0;
        duty_sh[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (mode_wr[c]) begin
          mode[c] <= mode_e'(apb.pwdata[1:0]);
          inv[c]  <= apb.pwdata[2];
          ie[c]   <= apb.pwdata[3];
        end
        if (period_wr[c]) period_sh[c] <= apb.pwdata[CNT_W-1:0];
        if (duty_wr[c])   duty_sh[c]   <= apb.pwdata[CNT_W-1:0];
      end
    end
  end

  // Per-channel counter, blink state and active period/duty copies
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      blink <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt[c]        <= '0;
        period_act[c] <= '0;
        duty_act[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (mode_wr[c]) begin
          cnt[c]   <= '0;
          blink[c] <= 1'b0;
        end else if (!running[c]) begin
          cnt[c] <= '0;
          if (!en) blink[c] <= 1'b0;
        end else if (wrap[c]) begin
          cnt[c]   <= '0;
          blink[c] <= ~blink[c];
        end else if (tick) begin
          cnt[c] <= cnt[c] + 1'b1;
        end
        // non-blocking read of the shadow: a shadow write on the wrap edge
        // is picked up only at the following wrap
        if (wrap[c] || !running[c]) begin
          period_act[c] <= period_sh[c];
          duty_act[c]   <= duty_sh[c];
        end
      end
    end
  end

  // Registered pad outputs and wrap interrupt pulses
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq      <= '0;
    end else begin
      gpio_out <= raw ^ inv;
      gpio_oe  <= oe_d;
      irq      <= wrap & ie;
    end
  end

  // Combinational APB read mux
  always_comb begin
    rdata = '0;
    cnt24 = '0;
    if (glb_hit) begin
      rdata[0]           = en;
      rdata[16 +: PRE_W] = prescale;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (word_ok && (apb.paddr[7:4] == 4'(c + 1))) begin
        case (apb.paddr[3:2])
          2'd0: rdata = {28'd0, ie[c], inv[c], mode[c]};
          2'd1: rdata = 32'(period_sh[c]);
          2'd2: rdata = 32'(duty_sh[c]);
          default: begin
            cnt24 = 24'(cnt[c]);
            rdata = {cnt24, 6'd0, blink[c], gpio_out[c]};
          end
        endcase
      end
    end
    apb.prdata = rd_en ? rdata : '0;
  end

endmodule

// File: tb/tb_apb_gpio_pwm_blinker.sv
// Scoreboard bench for apb_gpio_pwm_blinker: expectations are queued when the
// stimulus is applied and popped when the matching DUT observation is taken.
module tb_apb_gpio_pwm_blinker;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned PRE_W  = 16;

  logic              PCLK = 1'b0;
  logic              PRESETN = 1'b0;
  logic [NUM_CH-1:0] gpio_out, gpio_oe, irq;

  apb_gpio_pwm_blinker_if apb ();

  apb_gpio_pwm_blinker #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .apb     (apb),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  // Output monitor: logs every gpio_out transition and irq pulse per channel
  typedef struct { int unsigned t; int unsigned ch; logic lvl; } ev_t;
  ev_t               edges[$];
  ev_t               irqs[$];
  int unsigned       cyc = 0;
  logic [NUM_CH-1:0] prev_out = '0;

  always @(negedge PCLK) begin
    cyc++;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (gpio_out[c] !== prev_out[c]) edges.push_back('{cyc, c, gpio_out[c]});
      if (irq[c] === 1'b1) irqs.push_back('{cyc, c, 1'b1});
    end
    prev_out = gpio_out;
  end

  task automatic clear_mon();
    edges.delete();
    irqs.delete();
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = a; apb.pwdata = d;
    @(negedge PCLK);
    apb.penable = 1'b1;
    @(posedge PCLK); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = a;
    #1 d = apb.prdata;
    @(negedge PCLK);
    apb.penable = 1'b1;
    @(posedge PCLK); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [7:0] a,
                             input logic [31:0] exp, input logic [31:0] mask);
    logic [31:0] d;
    sb_push(tag, exp & mask);
    apb_read(a, d);
    sb_pop(d & mask);
  endtask

  // Pops n run lengths (cycles at level lvl between two transitions) of channel ch
  task automatic pop_runs(input int unsigned ch, input logic lvl, input int unsigned n);
    int unsigned got = 0;
    int unsigned t0  = 0;
    bit          open = 0;
    foreach (edges[i]) begin
      if (edges[i].ch == ch) begin
        if (open && got < n) begin
          sb_pop(edges[i].t - t0);
          got++;
        end
        open = (edges[i].lvl == lvl);
        t0   = edges[i].t;
      end
    end
    while (got < n) begin
      sb_pop(32'hFFFF_FFFF);
      got++;
    end
  endtask

  function automatic int unsigned count_edges(input int unsigned ch);
    int unsigned n = 0;
    foreach (edges[i]) if (edges[i].ch == ch) n++;
    return n;
  endfunction

  // Clears the log, then waits (bounded) until a rising edge of ch is logged
  task automatic wait_rise(input int unsigned ch);
    bit seen = 0;
    @(negedge PCLK); #2;
    clear_mon();
    for (int unsigned k = 0; k < 200 && !seen; k++) begin
      @(negedge PCLK); #2;
      foreach (edges[i]) if (edges[i].ch == ch && edges[i].lvl) seen = 1;
    end
    check("wait_rise", seen, 1);
  endtask

  initial begin
    logic [31:0] d;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;

    // reset state
    repeat (3) @(negedge PCLK);
    sb_push("rst_out", 0); sb_push("rst_oe", 0); sb_push("rst_irq", 0); sb_push("rst_prdata_idle", 0);
    sb_pop(gpio_out); sb_pop(gpio_oe); sb_pop(irq); sb_pop(apb.prdata);
    PRESETN = 1'b1;
    expect_read("rst_global", 8'h00, 0, '1);
    for (int unsigned c = 0; c < NUM_CH; c++)
      for (int unsigned r = 0; r < 4; r++)
        expect_read($sformatf("rst_ch%0d_r%0d", c, r), 8'(8'h10 + 16 * c + 4 * r), 0, '1);

    // blink: PRESCALE=0, ch0 PERIOD=3, MODE=blink with IE
    apb_write(8'h14, 3);
    apb_write(8'h10, 32'hA);
    apb_write(8'h00, 32'h1);
    expect_read("blink_period_rd", 8'h14, 3, '1);
    expect_read("blink_mode_rd", 8'h10, 32'hA, '1);
    expect_read("blink_global_rd", 8'h00, 1, '1);
    clear_mon();
    sb_push("blink_hi", 4); sb_push("blink_hi", 4);
    sb_push("blink_lo", 4); sb_push("blink_lo", 4);
    repeat (40) @(negedge PCLK);
    pop_runs(0, 1'b1, 2);
    pop_runs(0, 1'b0, 2);
    sb_push("blink_oe", 1);
    sb_pop(gpio_oe[0]);
    begin
      int unsigned n_irq = 0;
      int unsigned t_prev = 0;
      foreach (irqs[i]) begin
        if (irqs[i].ch == 0 && n_irq < 3) begin
          bit found = 0;
          foreach (edges[j]) if (edges[j].ch == 0 && edges[j].t == irqs[i].t + 1) found = 1;
          sb_push("blink_irq_toggle", 1);
          sb_pop(found);
          if (n_irq > 0) begin
            sb_push("blink_irq_gap", 4);
            sb_pop(irqs[i].t - t_prev);
          end
          t_prev = irqs[i].t;
          n_irq++;
        end
      end
      sb_push("blink_irq_count", 3);
      sb_pop(n_irq);
    end

    // pwm: PRESCALE=1, ch1 PERIOD=9 DUTY=3 -> 6 high / 14 low
    apb_write(8'h00, 32'h0001_0001);
    apb_write(8'h24, 9);
    apb_write(8'h28, 3);
    apb_write(8'h20, 3);
    expect_read("pwm_period_rd", 8'h24, 9, '1);
    expect_read("pwm_duty_rd", 8'h28, 3, '1);
    repeat (25) @(negedge PCLK);
    clear_mon();
    sb_push("pwm_hi", 6);  sb_push("pwm_hi", 6);
    sb_push("pwm_lo", 14); sb_push("pwm_lo", 14);
    repeat (80) @(negedge PCLK);
    pop_runs(1, 1'b1, 2);
    pop_runs(1, 1'b0, 2);

    // pwm inverted
    apb_write(8'h20, 7);
    expect_read("pwm_inv_mode_rd", 8'h20, 7, '1);
    repeat (25) @(negedge PCLK);
    clear_mon();
    sb_push("pwm_inv_hi", 14); sb_push("pwm_inv_hi", 14);
    sb_push("pwm_inv_lo", 6);  sb_push("pwm_inv_lo", 6);
    repeat (80) @(negedge PCLK);
    pop_runs(1, 1'b1, 2);
    pop_runs(1, 1'b0, 2);
    apb_write(8'h20, 3);
    repeat (25) @(negedge PCLK);

    // shadow: DUTY=7 written inside the high phase -> current 6, next 14
    wait_rise(1);
    apb_write(8'h28, 7);
    sb_push("shadow_mid_cur", 6); sb_push("shadow_mid_next", 14);
    repeat (70) @(negedge PCLK);
    pop_runs(1, 1'b1, 2);

    // shadow: DUTY=3 committed on the wrap edge -> deferred one period
    wait_rise(1);
    repeat (16) @(negedge PCLK);
    apb_write(8'h28, 3);
    sb_push("shadow_wrap_cur", 14); sb_push("shadow_wrap_defer", 14); sb_push("shadow_wrap_new", 6);
    repeat (70) @(negedge PCLK);
    pop_runs(1, 1'b1, 3);

    // edges: DUTY=0 constant low, DUTY=12 > PERIOD constant high
    apb_write(8'h28, 0);
    repeat (45) @(negedge PCLK);
    clear_mon();
    sb_push("duty0_edges", 0); sb_push("duty0_level", 0);
    repeat (40) @(negedge PCLK);
    sb_pop(count_edges(1)); sb_pop(gpio_out[1]);
    apb_write(8'h28, 12);
    repeat (45) @(negedge PCLK);
    clear_mon();
    sb_push("duty12_edges", 0); sb_push("duty12_level", 1);
    repeat (40) @(negedge PCLK);
    sb_pop(count_edges(1)); sb_pop(gpio_out[1]);

    // PERIOD=0 blink toggles on every tick (tick every 2 cycles)
    apb_write(8'h14, 0);
    repeat (20) @(negedge PCLK);
    clear_mon();
    sb_push("p0_hi", 2); sb_push("p0_hi", 2);
    sb_push("p0_lo", 2); sb_push("p0_lo", 2);
    repeat (30) @(negedge PCLK);
    pop_runs(0, 1'b1, 2);
    pop_runs(0, 1'b0, 2);

    // EN drop: counters and blink clear, mode-on channel keeps driving
    apb_write(8'h30, 1);
    apb_write(8'h00, 32'h0001_0000);
    repeat (3) @(negedge PCLK);
    expect_read("endrop_ch0_status", 8'h1C, 0, 32'hFFFF_FF02);
    expect_read("endrop_ch1_status", 8'h2C, 0, 32'hFFFF_FF00);
    sb_push("endrop_on_out", 1); sb_push("endrop_on_oe", 1); sb_push("endrop_blink_out", 0);
    sb_pop(gpio_out[2]); sb_pop(gpio_oe[2]); sb_pop(gpio_out[0]);

    // MODE rewrite with identical value restarts blink from state 0
    apb_write(8'h00, 32'h0001_0001);
    repeat (7) @(negedge PCLK);
    apb_write(8'h10, 32'h2);
    expect_read("moderw_status", 8'h1C, 0, 32'hFFFF_FF02);

    // unmapped address
    expect_read("unmapped_rd", 8'hF0, 0, '1);
    apb_write(8'hF0, 32'hFFFF_FFFF);
    expect_read("unmapped_rd2", 8'hF0, 0, '1);
    expect_read("unmapped_global", 8'h00, 32'h0001_0001, '1);
    expect_read("unmapped_ch0_mode", 8'h10, 2, '1);
    sb_push("unmapped_oe", 4'b0111);
    sb_pop(gpio_oe);

    // asynchronous reset in the middle of operation
    @(negedge PCLK); #3;
    PRESETN = 1'b0;
    #1;
    sb_push("arst_out", 0); sb_push("arst_oe", 0); sb_push("arst_irq", 0);
    sb_pop(gpio_out); sb_pop(gpio_oe); sb_pop(irq);
    @(negedge PCLK);
    PRESETN = 1'b1;
    expect_read("arst_global", 8'h00, 0, '1);
    expect_read("arst_ch1_mode", 8'h20, 0, '1);
    expect_read("arst_ch1_duty", 8'h28, 0, '1);

    sb_push("sb_drained", 0);
    sb_pop(sb_q.size() - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
